// File: rtl/cache_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter_if
// Description : Bundle of the two requester ports and the cache-side port
//               of the two-port cache request arbiter.
//                 req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requests
//                 ack0/ack1, err0/err1, rdata0/rdata1            : responses
//                 c_req, c_we, c_addr, c_wdata                   : to cache
//                 c_ready, c_rdata                               : from cache
//                 grant                                          : port served
//               modport slave  : the arbiter
//               modport master : requesters plus cache (environment side)
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ready;
    logic [DATA_W-1:0] c_rdata;
    logic              grant;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  c_ready, c_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output c_req, c_we, c_addr, c_wdata, grant
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output c_ready, c_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  c_req, c_we, c_addr, c_wdata, grant
    );
endinterface
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_arbiter
// Description : Round-robin arbiter between two requesters in front of a
//               single cache CPU-side port. Latches the winner's request,
//               holds it on the cache port until c_ready or a watchdog
//               expiry, then returns data/err with a one-cycle ack.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - cache_req_arbiter_if.slave (request, response and
//                      cache-side signals, all outputs registered)
// Parameters  : ADDR_W, DATA_W - address / data widths
//               TIMEOUT        - max BUSY cycles before error completion (>=2)
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_req_arbiter_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last;   // port served most recently
    logic [CNT_W-1:0]  r_cnt;    // BUSY-cycle watchdog

    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // On a tie the port that was not served last wins; otherwise whichever
    // port is requesting (w_sel is don't-care when neither requests).
    assign w_any   = bus.req0 | bus.req1;
    assign w_sel   = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_we    = w_sel ? bus.we1    : bus.we0;
    assign w_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_wdata = w_sel ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            bus.c_req   <= 1'b0;
            bus.c_we    <= 1'b0;
            bus.c_addr  <= '0;
            bus.c_wdata <= '0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
            bus.grant   <= 1'b0;
        end else begin
            // ack is a single-cycle pulse, raised only on entry to DONE
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        bus.grant   <= w_sel;
                        bus.c_we    <= w_we;
                        bus.c_addr  <= w_addr;
                        bus.c_wdata <= w_wdata;
                        bus.c_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // c_ready wins over a watchdog expiry in the same cycle
                    if (bus.c_ready || (r_cnt == C_CNT_LAST)) begin
                        bus.c_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (bus.grant) begin
                            bus.ack1 <= 1'b1;
                            bus.err1 <= ~bus.c_ready;
                            if (bus.c_ready && !bus.c_we) begin
                                bus.rdata1 <= bus.c_rdata;
                            end
                        end else begin
                            bus.ack0 <= 1'b1;
                            bus.err0 <= ~bus.c_ready;
                            if (bus.c_ready && !bus.c_we) begin
                                bus.rdata0 <= bus.c_rdata;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_last  <= bus.grant;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_req_arbiter
// Description : Self-checking bench for cache_req_arbiter. A reference model
//               orders requests by the round-robin rule and predicts every
//               ack (port, err, rdata of both ports); a cache responder
//               model answers after a chosen latency and checks the latched
//               cache-side fields; a monitor pops predictions on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_req_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 8;
    localparam int TIMEOUT      = 16;
    localparam int NEVER        = 1000;
    localparam int ROUND_BUDGET = 150;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;     // BUSY cycle on which the cache answers
        logic [7:0] cdata;
    } txn_t;

    typedef struct {
        int         port;
        logic       err;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;

    logic clk;
    logic rst;

    cache_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_req_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    txn_t cache_q[$];
    txn_t pq0[$];
    txn_t pq1[$];
    int   order_q[$];
    int   model_last;
    logic [7:0] model_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk_txn(int p, logic we, logic [7:0] a, logic [7:0] wd, int lat, logic [7:0] cd);
        txn_t t;
        t.port = p; t.we = we; t.addr = a; t.wdata = wd; t.lat = lat; t.cdata = cd;
        return t;
    endfunction

    function automatic txn_t rand_txn(int p);
        int r;
        int lat;
        r = int'($urandom_range(0, 9));
        if (r < 6)       lat = int'($urandom_range(1, 4));
        else if (r == 6) lat = TIMEOUT;
        else if (r == 7) lat = TIMEOUT - 1;
        else             lat = NEVER;
        return mk_txn(p, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), lat, 8'($urandom));
    endfunction

    // Reference model: both ports present all their requests at once and
    // keep req high back-to-back, so service order follows directly from
    // the round-robin rule over the pending counts.
    task automatic plan();
        int r0, r1, k0, k1, p;
        txn_t t;
        exp_t e;
        r0 = pq0.size(); r1 = pq1.size(); k0 = 0; k1 = 0;
        while (r0 + r1 > 0) begin
            if (r0 > 0 && r1 > 0) p = 1 - model_last;
            else if (r0 > 0)      p = 0;
            else                  p = 1;
            if (p == 0) begin t = pq0[k0]; k0++; r0--; end
            else        begin t = pq1[k1]; k1++; r1--; end
            model_last = p;
            if (t.lat <= TIMEOUT && !t.we) model_rd[p] = t.cdata;
            e.port = p;
            e.err  = (t.lat > TIMEOUT);
            e.rd0  = model_rd[0];
            e.rd1  = model_rd[1];
            cache_q.push_back(t);
            sb_q.push_back(e);
            order_q.push_back(p);
        end
    endtask

    task automatic drive_port(input int p, input txn_t t);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
        end
    endtask

    // Fields of a port already granted must not reach the cache
    task automatic scramble(input int p);
        if (p == 0) begin
            bus.we0 = ~bus.we0; bus.addr0 = 8'($urandom); bus.wdata0 = 8'($urandom);
        end else begin
            bus.we1 = ~bus.we1; bus.addr1 = 8'($urandom); bus.wdata1 = 8'($urandom);
        end
    endtask

    task automatic run_round();
        int n0, n1, i0, i1, cyc;
        n0 = pq0.size(); n1 = pq1.size();
        plan();
        i0 = 0; i1 = 0; cyc = 0;
        if (n0 > 0) drive_port(0, pq0[0]);
        if (n1 > 0) drive_port(1, pq1[0]);
        while ((i0 < n0 || i1 < n1) && cyc < ROUND_BUDGET) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0) begin
                i0++;
                void'(order_q.pop_front());
                if (i0 < n0) drive_port(0, pq0[i0]); else bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                i1++;
                void'(order_q.pop_front());
                if (i1 < n1) drive_port(1, pq1[i1]); else bus.req1 = 1'b0;
            end
            if (bus.c_req && order_q.size() > 0) scramble(order_q[0]);
        end
        if (i0 < n0 || i1 < n1) begin
            vectors++;
            miscompares++;
            $display("FAIL round_timeout: acks got %0d/%0d expected %0d/%0d", i0, i1, n0, n1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        pq0.delete();
        pq1.delete();
        order_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_c_req"},   32'(bus.c_req),   32'd0);
        check({tag, "_c_we"},    32'(bus.c_we),    32'd0);
        check({tag, "_c_addr"},  32'(bus.c_addr),  32'd0);
        check({tag, "_c_wdata"}, 32'(bus.c_wdata), 32'd0);
        check({tag, "_acks"},    32'({bus.ack1, bus.ack0}), 32'd0);
        check({tag, "_errs"},    32'({bus.err1, bus.err0}), 32'd0);
        check({tag, "_rdata0"},  32'(bus.rdata0),  32'd0);
        check({tag, "_rdata1"},  32'(bus.rdata1),  32'd0);
        check({tag, "_grant"},   32'(bus.grant),   32'd0);
    endtask

    // Cache responder: answers on the chosen BUSY cycle, toggles c_ready
    // randomly while not BUSY, and checks latched fields and BUSY length.
    initial begin : cache_model
        txn_t cur;
        int   cnt;
        int   exp_len;
        cnt = 0;
        cur = mk_txn(0, 1'b0, 8'h00, 8'h00, NEVER, 8'h00);
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                bus.c_ready = 1'b0;
            end else if (bus.c_req) begin
                if (cnt == 0) begin
                    if (cache_q.size() > 0) begin
                        cur = cache_q.pop_front();
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_c_req: got c_req=1 expected no pending request");
                        cur = mk_txn(0, 1'b0, 8'h00, 8'h00, NEVER, 8'h00);
                    end
                end
                cnt++;
                check("c_addr",  32'(bus.c_addr),  32'(cur.addr));
                check("c_we",    32'(bus.c_we),    32'(cur.we));
                check("c_wdata", 32'(bus.c_wdata), 32'(cur.wdata));
                bus.c_ready = (cnt == cur.lat);
                bus.c_rdata = (cnt == cur.lat) ? cur.cdata : 8'($urandom);
            end else begin
                if (cnt > 0) begin
                    exp_len = (cur.lat <= TIMEOUT) ? cur.lat : TIMEOUT;
                    check("busy_len", 32'(cnt), 32'(exp_len));
                end
                cnt = 0;
                bus.c_ready = 1'($urandom_range(0, 1));
                bus.c_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: pops the model's prediction whenever an ack appears
    initial begin : monitor
        exp_t e;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ack) check("ack_width", 32'(bus.ack0 | bus.ack1), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", 32'({bus.ack1, bus.ack0}), (e.port == 1) ? 32'd2 : 32'd1);
                    check("grant",    32'(bus.grant), 32'(e.port));
                    check("err",      32'((e.port == 1) ? bus.err1 : bus.err0), 32'(e.err));
                    check("rdata0",   32'(bus.rdata0), 32'(e.rd0));
                    check("rdata1",   32'(bus.rdata1), 32'(e.rd1));
                    check("c_req_in_done", 32'(bus.c_req), 32'd0);
                end
            end
            prev_ack = bus.ack0 | bus.ack1;
        end
    end

    initial begin : driver
        int   cyc;
        int   n0, n1;
        txn_t t;
        model_last  = 1;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.c_ready = 1'b0; bus.c_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset, immediate cache: grants 0,1,0
        pq0.push_back(mk_txn(0, 1'b0, 8'h01, 8'h00, 1, 8'h11));
        pq0.push_back(mk_txn(0, 1'b0, 8'h02, 8'h00, 1, 8'h22));
        pq1.push_back(mk_txn(1, 1'b0, 8'h81, 8'h00, 1, 8'h33));
        run_round();
        // Single read
        pq0.push_back(mk_txn(0, 1'b0, 8'h3A, 8'h00, 2, 8'h5C));
        run_round();
        // Write, fields scrambled after grant
        pq1.push_back(mk_txn(1, 1'b1, 8'h10, 8'hAA, 3, 8'h77));
        run_round();
        // Timeout, then a normal request
        pq0.push_back(mk_txn(0, 1'b0, 8'h44, 8'h00, NEVER, 8'h99));
        run_round();
        pq0.push_back(mk_txn(0, 1'b0, 8'h45, 8'h00, 2, 8'h66));
        run_round();
        // c_ready on the final watchdog cycle
        pq0.push_back(mk_txn(0, 1'b0, 8'h46, 8'h00, TIMEOUT, 8'hC3));
        run_round();

        // Reset in the 3rd BUSY cycle; transaction abandoned with no ack
        t = mk_txn(0, 1'b0, 8'h55, 8'h00, NEVER, 8'h00);
        cache_q.push_back(t);
        drive_port(0, t);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.c_req && cyc < 10);
        check("rst_test_c_req_seen", 32'(bus.c_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        cache_q.delete();
        model_last  = 1;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        pq1.push_back(mk_txn(1, 1'b0, 8'h21, 8'h00, 2, 8'hE5));
        run_round();
        pq0.push_back(mk_txn(0, 1'b0, 8'h31, 8'h00, 1, 8'h5A));
        pq1.push_back(mk_txn(1, 1'b1, 8'h32, 8'hF0, 1, 8'hA5));
        run_round();

        // Randomised rounds
        for (int r = 0; r < 40; r++) begin
            do begin
                n0 = int'($urandom_range(0, 2));
                n1 = int'($urandom_range(0, 2));
            end while (n0 + n1 == 0);
            for (int i = 0; i < n0; i++) pq0.push_back(rand_txn(0));
            for (int i = 0; i < n1; i++) pq1.push_back(rand_txn(1));
            run_round();
        end

        cyc = 0;
        while (sb_q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("sb_drained",    32'(sb_q.size()),    32'd0);
        check("cache_drained", 32'(cache_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
